cache_replacer: RTL and testbench

CACHE_REPLACER -- requirements
Module: cache_replacer

---
 rtl/cache_replacer_if.sv | 39 +++
 rtl/cache_replacer.sv | 91 +++++++++
 tb/tb_cache_replacer.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_replacer_if.sv
// Bundle of the cache_replacer update, query and victim-response signals.
// The replacer is the slave, and the cache controller is the master.
interface cache_replacer_if #(
   parameter int SET_NUM  = 8,
   parameter int SET_SIZE = 4
);
   localparam int SW = (SET_NUM > 1) ? $clog2(SET_NUM) : 1;
   localparam int WW = $clog2(SET_SIZE);

   logic          touch_valid;
   logic [SW-1:0] touch_set;
   logic [WW-1:0] touch_way;
   logic          fill_valid;
   logic [SW-1:0] fill_set;
   logic [WW-1:0] fill_way;
   logic          inv_valid;
   logic [SW-1:0] inv_set;
   logic [WW-1:0] inv_way;
   logic          query_valid;
   logic [SW-1:0] query_set;
   logic          victim_valid;
   logic [WW-1:0] victim_way;

   modport master (
      output touch_valid, touch_set, touch_way,
      output fill_valid, fill_set, fill_way,
      output inv_valid, inv_set, inv_way,
      output query_valid, query_set,
      input  victim_valid, victim_way
   );

   modport slave (
      input  touch_valid, touch_set, touch_way,
      input  fill_valid, fill_set, fill_way,
      input  inv_valid, inv_set, inv_way,
      input  query_valid, query_set,
      output victim_valid, victim_way
   );
endinterface

// File: rtl/cache_replacer.sv
// Per-set rank/valid replacement state with LRU, FIFO or LFSR-random victim selection.
// A victim is answered one cycle after each query, and the answer is taken from the pre-update state.
module cache_replacer #(
   parameter int SET_NUM  = 8,
   parameter int SET_SIZE = 4,
   parameter int MODE     = 0
) (
   input logic            clk,
   input logic            resetn,
   cache_replacer_if.slave bus
);
   localparam int SW = (SET_NUM > 1) ? $clog2(SET_NUM) : 1;
   localparam int WW = $clog2(SET_SIZE);

   typedef logic [SET_SIZE-1:0][WW-1:0] rank_vec_t;
   typedef logic [SET_SIZE-1:0]         valid_vec_t;

   rank_vec_t     rank_q  [SET_NUM];
   rank_vec_t     rank_d  [SET_NUM];
   valid_vec_t    valid_q [SET_NUM];
   valid_vec_t    valid_d [SET_NUM];
   logic [15:0]   lfsr_q, lfsr_d;
   logic          victim_valid_q;
   logic [WW-1:0] victim_way_q, victim_way_d;

   // Ways ranked above w slide down one, and w becomes the newest.
   function automatic rank_vec_t promote(input rank_vec_t r, input logic [WW-1:0] w);
      rank_vec_t res;
      res = r;
      for (int j = 0; j < SET_SIZE; j++) begin
         if (r[j] > r[w]) res[j] = r[j] - WW'(1);
      end
      res[w] = WW'(SET_SIZE - 1);
      return res;
   endfunction

   function automatic logic [WW-1:0] pick_victim(input rank_vec_t r, input valid_vec_t v,
                                                 input logic [WW-1:0] rnd);
      logic [WW-1:0] sel;
      sel = rnd;
      if (MODE != 2) begin
         for (int j = 0; j < SET_SIZE; j++) begin
            if (r[j] == '0) sel = WW'(j);
         end
      end
      // The scan runs downward, so the lowest-index invalid way is written last and wins.
      for (int j = SET_SIZE - 1; j >= 0; j--) begin
         if (!v[j]) sel = WW'(j);
      end
      return sel;
   endfunction

   always_comb begin
      for (int s = 0; s < SET_NUM; s++) begin
         rank_d[s]  = rank_q[s];
         valid_d[s] = valid_q[s];
         if (bus.inv_valid && bus.inv_set == SW'(s)) valid_d[s][bus.inv_way] = 1'b0;
         // A fill to the set wins over a touch to the same set; the touch is dropped.
         if (bus.fill_valid && bus.fill_set == SW'(s)) begin
            rank_d[s]                   = promote(rank_q[s], bus.fill_way);
            valid_d[s][bus.fill_way]    = 1'b1;
         end else if (MODE == 0 && bus.touch_valid && bus.touch_set == SW'(s)) begin
            rank_d[s] = promote(rank_q[s], bus.touch_way);
         end
      end
      // The LFSR shifts right with taps 16,14,13,11, counting the bits 1..16 from the LSB.
      lfsr_d       = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
      victim_way_d = pick_victim(rank_q[bus.query_set], valid_q[bus.query_set], lfsr_q[WW-1:0]);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int s = 0; s < SET_NUM; s++) begin
            for (int i = 0; i < SET_SIZE; i++) rank_q[s][i] <= WW'(i);
            valid_q[s] <= '0;
         end
         lfsr_q         <= 16'hACE1;
         victim_valid_q <= 1'b0;
         victim_way_q   <= '0;
      end else begin
         rank_q         <= rank_d;
         valid_q        <= valid_d;
         lfsr_q         <= lfsr_d;
         victim_valid_q <= bus.query_valid;
         if (bus.query_valid) victim_way_q <= victim_way_d;
      end
   end

   assign bus.victim_valid = victim_valid_q;
   assign bus.victim_way   = victim_way_q;
endmodule

// File: tb/tb_cache_replacer.sv
// Directed bench for cache_replacer: one shared stimulus bus drives an LRU, a FIFO and a RANDOM instance.
// The bench checks each scenario against victim ways that were worked out by hand or taken from an LFSR reference.
module tb_cache_replacer;
   localparam int SN = 8;
   localparam int SS = 4;

   logic       clk = 1'b0;
   logic       resetn;
   logic       tv, fv, iv, qv;
   logic [2:0] ts, fs, is, qs;
   logic [1:0] tw, fw, iw;
   logic [15:0] lfsr_m;
   logic [1:0]  exp_w;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cache_replacer_if #(.SET_NUM(SN), .SET_SIZE(SS)) if_lru  ();
   cache_replacer_if #(.SET_NUM(SN), .SET_SIZE(SS)) if_fifo ();
   cache_replacer_if #(.SET_NUM(SN), .SET_SIZE(SS)) if_rnd  ();

   assign if_lru.touch_valid  = tv;  assign if_lru.touch_set  = ts;  assign if_lru.touch_way  = tw;
   assign if_lru.fill_valid   = fv;  assign if_lru.fill_set   = fs;  assign if_lru.fill_way   = fw;
   assign if_lru.inv_valid    = iv;  assign if_lru.inv_set    = is;  assign if_lru.inv_way    = iw;
   assign if_lru.query_valid  = qv;  assign if_lru.query_set  = qs;
   assign if_fifo.touch_valid = tv;  assign if_fifo.touch_set = ts;  assign if_fifo.touch_way = tw;
   assign if_fifo.fill_valid  = fv;  assign if_fifo.fill_set  = fs;  assign if_fifo.fill_way  = fw;
   assign if_fifo.inv_valid   = iv;  assign if_fifo.inv_set   = is;  assign if_fifo.inv_way   = iw;
   assign if_fifo.query_valid = qv;  assign if_fifo.query_set = qs;
   assign if_rnd.touch_valid  = tv;  assign if_rnd.touch_set  = ts;  assign if_rnd.touch_way  = tw;
   assign if_rnd.fill_valid   = fv;  assign if_rnd.fill_set   = fs;  assign if_rnd.fill_way   = fw;
   assign if_rnd.inv_valid    = iv;  assign if_rnd.inv_set    = is;  assign if_rnd.inv_way    = iw;
   assign if_rnd.query_valid  = qv;  assign if_rnd.query_set  = qs;

   cache_replacer #(.SET_NUM(SN), .SET_SIZE(SS), .MODE(0)) u_lru  (.clk(clk), .resetn(resetn), .bus(if_lru));
   cache_replacer #(.SET_NUM(SN), .SET_SIZE(SS), .MODE(1)) u_fifo (.clk(clk), .resetn(resetn), .bus(if_fifo));
   cache_replacer #(.SET_NUM(SN), .SET_SIZE(SS), .MODE(2)) u_rnd  (.clk(clk), .resetn(resetn), .bus(if_rnd));

   // Reference LFSR: seed 16'hACE1, taps 16,14,13,11, shifting right.
   always @(posedge clk or negedge resetn) begin
      if (!resetn) lfsr_m <= 16'hACE1;
      else         lfsr_m <= {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      tv = 0; fv = 0; iv = 0; qv = 0;
      ts = 0; fs = 0; is = 0; qs = 0;
      tw = 0; fw = 0; iw = 0;
   endtask

   task automatic fill(input logic [2:0] s, input logic [1:0] w);
      fv = 1; fs = s; fw = w; cyc(); fv = 0;
   endtask

   task automatic touch(input logic [2:0] s, input logic [1:0] w);
      tv = 1; ts = s; tw = w; cyc(); tv = 0;
   endtask

   task automatic inv(input logic [2:0] s, input logic [1:0] w);
      iv = 1; is = s; iw = w; cyc(); iv = 0;
   endtask

   task automatic query(input logic [2:0] s);
      qv = 1; qs = s; cyc(); qv = 0;
   endtask

   task automatic test_reset();
      idle();
      resetn = 0;
      #3;
      checks++;
      if ({if_lru.victim_valid, if_lru.victim_way} !== 3'b000) begin
         errors++; $display("FAIL reset_lru got %0b/%0d want 0/0", if_lru.victim_valid, if_lru.victim_way);
      end
      checks++;
      if ({if_fifo.victim_valid, if_fifo.victim_way} !== 3'b000) begin
         errors++; $display("FAIL reset_fifo got %0b/%0d want 0/0", if_fifo.victim_valid, if_fifo.victim_way);
      end
      checks++;
      if ({if_rnd.victim_valid, if_rnd.victim_way} !== 3'b000) begin
         errors++; $display("FAIL reset_rnd got %0b/%0d want 0/0", if_rnd.victim_valid, if_rnd.victim_way);
      end
      repeat (2) @(posedge clk);
      #1 resetn = 1;
      query(3);
      checks++;
      if ({if_lru.victim_valid, if_lru.victim_way} !== {1'b1, 2'd0}) begin
         errors++; $display("FAIL first_query got %0b/%0d want 1/0", if_lru.victim_valid, if_lru.victim_way);
      end
      checks++;
      if ({if_rnd.victim_valid, if_rnd.victim_way} !== {1'b1, 2'd0}) begin
         errors++; $display("FAIL first_query_rnd got %0b/%0d want 1/0", if_rnd.victim_valid, if_rnd.victim_way);
      end
      cyc();
      checks++;
      if (if_lru.victim_valid !== 1'b0) begin
         errors++; $display("FAIL valid_one_cycle got %0b want 0", if_lru.victim_valid);
      end
   endtask

   task automatic test_lru_order();
      for (int w = 0; w < 4; w++) fill(3'd2, 2'(w));
      touch(3'd2, 2'd0);
      touch(3'd2, 2'd2);
      query(3'd2);
      checks++;
      if ({if_lru.victim_valid, if_lru.victim_way} !== {1'b1, 2'd1}) begin
         errors++; $display("FAIL lru_order got %0b/%0d want 1/1", if_lru.victim_valid, if_lru.victim_way);
      end
      query(3'd2);
      checks++;
      if ({if_lru.victim_valid, if_lru.victim_way} !== {1'b1, 2'd1}) begin
         errors++; $display("FAIL lru_requery got %0b/%0d want 1/1", if_lru.victim_valid, if_lru.victim_way);
      end
      checks++;
      if (if_fifo.victim_way !== 2'd0) begin
         errors++; $display("FAIL fifo_ignores_touch got %0d want 0", if_fifo.victim_way);
      end
   endtask

   task automatic test_fifo();
      for (int w = 0; w < 4; w++) fill(3'd5, 2'(w));
      repeat (3) touch(3'd5, 2'd0);
      query(3'd5);
      checks++;
      if ({if_fifo.victim_valid, if_fifo.victim_way} !== {1'b1, 2'd0}) begin
         errors++; $display("FAIL fifo_oldest got %0b/%0d want 1/0", if_fifo.victim_valid, if_fifo.victim_way);
      end
      checks++;
      if (if_lru.victim_way !== 2'd1) begin
         errors++; $display("FAIL lru_after_touch got %0d want 1", if_lru.victim_way);
      end
      fill(3'd5, 2'd0);
      query(3'd5);
      checks++;
      if (if_fifo.victim_way !== 2'd1) begin
         errors++; $display("FAIL fifo_refill got %0d want 1", if_fifo.victim_way);
      end
   endtask

   task automatic test_invalidate();
      for (int w = 0; w < 4; w++) fill(3'd1, 2'(w));
      inv(3'd1, 2'd3);
      touch(3'd1, 2'd0);
      query(3'd1);
      checks++;
      if (if_lru.victim_way !== 2'd3) begin
         errors++; $display("FAIL lru_invalid_first got %0d want 3", if_lru.victim_way);
      end
      checks++;
      if (if_fifo.victim_way !== 2'd3) begin
         errors++; $display("FAIL fifo_invalid_first got %0d want 3", if_fifo.victim_way);
      end
      fill(3'd1, 2'd3);
      query(3'd1);
      checks++;
      if (if_lru.victim_way !== 2'd1) begin
         errors++; $display("FAIL inv_keeps_rank got %0d want 1", if_lru.victim_way);
      end
      checks++;
      if (if_fifo.victim_way !== 2'd0) begin
         errors++; $display("FAIL fifo_after_refill got %0d want 0", if_fifo.victim_way);
      end
      for (int w = 0; w < 4; w++) fill(3'd6, 2'(w));
      fv = 1; fs = 3'd6; fw = 2'd2; iv = 1; is = 3'd6; iw = 2'd2;
      cyc();
      idle();
      query(3'd6);
      checks++;
      if (if_lru.victim_way !== 2'd0) begin
         errors++; $display("FAIL fill_beats_inv got %0d want 0", if_lru.victim_way);
      end
   endtask

   task automatic test_same_cycle();
      for (int w = 0; w < 4; w++) fill(3'd4, 2'(w));
      touch(3'd4, 2'd0);
      query(3'd4);
      checks++;
      if (if_lru.victim_way !== 2'd1) begin
         errors++; $display("FAIL same_setup got %0d want 1", if_lru.victim_way);
      end
      fv = 1; fs = 3'd4; fw = 2'd1; tv = 1; ts = 3'd4; tw = 2'd2; qv = 1; qs = 3'd4;
      cyc();
      idle();
      checks++;
      if ({if_lru.victim_valid, if_lru.victim_way} !== {1'b1, 2'd1}) begin
         errors++; $display("FAIL query_pre_update got %0b/%0d want 1/1", if_lru.victim_valid, if_lru.victim_way);
      end
      query(3'd4);
      checks++;
      if (if_lru.victim_way !== 2'd2) begin
         errors++; $display("FAIL fill_beats_touch got %0d want 2", if_lru.victim_way);
      end
      for (int w = 0; w < 3; w++) fill(3'd7, 2'(w));
      fv = 1; fs = 3'd7; fw = 2'd3; tv = 1; ts = 3'd4; tw = 2'd2;
      cyc();
      idle();
      query(3'd4);
      checks++;
      if (if_lru.victim_way !== 2'd3) begin
         errors++; $display("FAIL cross_set_touch got %0d want 3", if_lru.victim_way);
      end
      query(3'd7);
      checks++;
      if (if_lru.victim_way !== 2'd0) begin
         errors++; $display("FAIL cross_set_fill got %0d want 0", if_lru.victim_way);
      end
   endtask

   task automatic test_back_to_back();
      qv = 1; qs = 3'd4;
      cyc();
      checks++;
      if ({if_lru.victim_valid, if_lru.victim_way} !== {1'b1, 2'd3}) begin
         errors++; $display("FAIL b2b_first got %0b/%0d want 1/3", if_lru.victim_valid, if_lru.victim_way);
      end
      qs = 3'd2;
      cyc();
      checks++;
      if ({if_lru.victim_valid, if_lru.victim_way} !== {1'b1, 2'd1}) begin
         errors++; $display("FAIL b2b_second got %0b/%0d want 1/1", if_lru.victim_valid, if_lru.victim_way);
      end
      qv = 0;
      cyc();
      checks++;
      if (if_lru.victim_valid !== 1'b0) begin
         errors++; $display("FAIL b2b_end got %0b want 0", if_lru.victim_valid);
      end
   endtask

   task automatic random_run(input int tag);
      for (int w = 0; w < 4; w++) fill(3'd0, 2'(w));
      for (int k = 0; k < 8; k++) begin
         qv = 1; qs = 3'd0;
         exp_w = lfsr_m[1:0];
         cyc();
         checks++;
         if ({if_rnd.victim_valid, if_rnd.victim_way} !== {1'b1, exp_w}) begin
            errors++;
            $display("FAIL rnd_seq run%0d step%0d got %0b/%0d want 1/%0d", tag, k,
                     if_rnd.victim_valid, if_rnd.victim_way, exp_w);
         end
      end
      qv = 0;
   endtask

   task automatic test_random();
      resetn = 0;
      cyc();
      cyc();
      resetn = 1;
      random_run(0);
      qv = 1; qs = 3'd0;
      cyc();
      qv = 0;
      #2 resetn = 0;
      #1;
      checks++;
      if ({if_rnd.victim_valid, if_rnd.victim_way} !== 3'b000) begin
         errors++; $display("FAIL async_reset_drop got %0b/%0d want 0/0", if_rnd.victim_valid, if_rnd.victim_way);
      end
      cyc();
      resetn = 1;
      random_run(1);
   endtask

   initial begin
      test_reset();
      test_lru_order();
      test_fifo();
      test_invalidate();
      test_same_cycle();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
